// File: rtl/target_scheduler.sv
// Per-frame colour tracker: walks the enabled target colours one frame at a time,
// accumulates pixel count and bounding box, and publishes one result per frame.
module target_scheduler #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int MIN_COUNT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  colour_mask,
  input  logic        pixel_valid,
  input  logic        sof,
  input  logic        eof,
  input  logic [4:0]  det_flags,
  output logic [2:0]  colour_sel,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [2:0]  res_colour,
  output logic [18:0] res_count,
  output logic        res_found,
  output logic [9:0]  res_x_min,
  output logic [9:0]  res_x_max,
  output logic [8:0]  res_y_min,
  output logic [8:0]  res_y_max,
  output logic        frame_drop
);

  typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH} state_t;
  state_t state;

  logic [9:0]  x_cnt, x_min, x_max;
  logic [8:0]  y_cnt, y_min, y_max;
  logic [18:0] count;

  // Next enabled colour strictly after cur in 0..4 cyclic order; cur itself if it is
  // the only enabled one, cur unchanged when nothing is enabled.
  function automatic logic [2:0] next_en(input logic [2:0] cur, input logic [4:0] mask);
    logic [2:0] r;
    int c;
    r = cur;
    for (int i = 5; i >= 1; i--) begin
      c = (int'(cur) + i) % 5;
      if (mask[c]) r = 3'(c);
    end
    return r;
  endfunction

  logic        start, accept, hit;
  logic [2:0]  adv_sel, track_sel;
  logic [9:0]  px, nx, b_xmin, b_xmax, n_xmin, n_xmax;
  logic [8:0]  py, ny, b_ymin, b_ymax, n_ymin, n_ymax;
  logic [18:0] b_count, n_count;

  always_comb begin
    adv_sel   = next_en(colour_sel, colour_mask);
    start     = pixel_valid && sof &&
                (((state == IDLE) && (colour_mask != '0)) || (state == ACCUM));
    accept    = pixel_valid && (start || (state == ACCUM));
    track_sel = ((state == IDLE) && !colour_mask[colour_sel]) ? adv_sel : colour_sel;
    hit       = det_flags[track_sel];

    px = sof ? '0 : x_cnt;
    py = sof ? '0 : y_cnt;
    if (px == 10'(IMG_WIDTH - 1)) begin
      nx = '0;
      ny = (py == 9'(IMG_HEIGHT - 1)) ? py : py + 9'd1;
    end else begin
      nx = px + 10'd1;
      ny = py;
    end

    // A sof pixel starts from the empty-frame accumulator, not the stale one.
    b_count = start ? '0 : count;
    b_xmin  = start ? '1 : x_min;
    b_xmax  = start ? '0 : x_max;
    b_ymin  = start ? '1 : y_min;
    b_ymax  = start ? '0 : y_max;

    n_count = b_count + 19'(hit);
    n_xmin  = (hit && (px < b_xmin)) ? px : b_xmin;
    n_xmax  = (hit && (px > b_xmax)) ? px : b_xmax;
    n_ymin  = (hit && (py < b_ymin)) ? py : b_ymin;
    n_ymax  = (hit && (py > b_ymax)) ? py : b_ymax;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      colour_sel <= '0;
      res_valid  <= 1'b0;
      res_colour <= '0;
      res_count  <= '0;
      res_found  <= 1'b0;
      res_x_min  <= '0;
      res_x_max  <= '0;
      res_y_min  <= '0;
      res_y_max  <= '0;
      frame_drop <= 1'b0;
      count      <= '0;
      x_min      <= '1;
      x_max      <= '0;
      y_min      <= '1;
      y_max      <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
    end else begin
      frame_drop <= (state == PUBLISH) && pixel_valid && sof;
      if (accept) begin
        colour_sel <= track_sel;
        count      <= n_count;
        x_min      <= n_xmin;
        x_max      <= n_xmax;
        y_min      <= n_ymin;
        y_max      <= n_ymax;
        x_cnt      <= nx;
        y_cnt      <= ny;
        if (eof) begin
          state      <= PUBLISH;
          res_valid  <= 1'b1;
          res_colour <= track_sel;
          res_count  <= n_count;
          res_found  <= (n_count != '0) && (n_count >= 19'(MIN_COUNT));
          res_x_min  <= (n_count == '0) ? '0 : n_xmin;
          res_x_max  <= (n_count == '0) ? '0 : n_xmax;
          res_y_min  <= (n_count == '0) ? '0 : n_ymin;
          res_y_max  <= (n_count == '0) ? '0 : n_ymax;
        end else begin
          state <= ACCUM;
        end
      end else if ((state == PUBLISH) && res_ready) begin
        state      <= IDLE;
        res_valid  <= 1'b0;
        colour_sel <= adv_sel;
      end
    end
  end

endmodule
